axis_packet_arbiter: RTL and testbench
======================================

Name: axis_packet_arbiter

Overview:
Packet-granular round-robin arbiter that merges NUM_PORTS AXI-stream packet sources onto one AXI-stream output. Each source is normally an axis_packet_fifo output, which only presents complete, non-dropped packets. A grant is locked from the first beat to the tlast beat, so packets never interleave. The output is a registered single-stage pipeline and carries the source index as m_axis_tid for downstream routing and statistics.

Parameters:
NUM_PORTS, 4, number of input streams (2..16)
TDATA_WIDTH, 32, data width per stream
ID_WIDTH, $clog2(NUM_PORTS), width of the port index (localparam)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
s_axis_tdata  input  NUM_PORTS*TDATA_WIDTH  input data; port i occupies bits [i*TDATA_WIDTH +: TDATA_WIDTH]
s_axis_tlast  input  NUM_PORTS  per-port end of packet
s_axis_tvalid  input  NUM_PORTS  per-port valid
s_axis_tready  output  NUM_PORTS  per-port ready; at most one bit high
port_enable  input  NUM_PORTS  per-port eligibility for new grants
m_axis_tdata  output  TDATA_WIDTH  merged data
m_axis_tlast  output  1  merged end of packet
m_axis_tid  output  ID_WIDTH  index of the source of the current beat
m_axis_tvalid  output  1  merged valid
m_axis_tready  input  1  downstream ready
busy  output  1  high while a grant is locked (state BUSY)

Behaviour:
- Reset (sync, active-high):
  - state=IDLE, grant=0, last_grant=NUM_PORTS-1, so port 0 has first priority.
  - m_axis_tvalid=0, m_axis_tdata/tlast/tid=0, s_axis_tready=0, busy=0.
  - Reset mid-packet abandons the packet; no partial beats appear after reset.
- Request vector: req = s_axis_tvalid & port_enable.
- State IDLE:
  - If req!=0, pick the first set bit searching last_grant+1, last_grant+2, ... with modulo wrap.
  - Register the pick into grant and move to BUSY.
  - s_axis_tready is all zero in IDLE.
- State BUSY:
  - accept = ~m_axis_tvalid | m_axis_tready.
  - s_axis_tready[grant] = accept; all other bits are 0.
  - On s_axis_tvalid[grant] & accept: load the output register with {data[grant], tlast[grant], grant} and set m_axis_tvalid=1.
  - If that beat has tlast=1: last_grant<=grant and state<=IDLE in the same cycle.
- Output register: when m_axis_tvalid & m_axis_tready and no new beat is loaded, clear m_axis_tvalid. Data must stay stable while tvalid=1 and tready=0 (AXI rule).
- Throughput: within a packet, 1 beat/cycle with downstream ready. Between packets there is exactly one idle input cycle (the arbitration cycle). First beat of a packet appears on m_axis 2 cycles after tvalid is seen in IDLE.
- port_enable is sampled only in IDLE. Deasserting port_enable[grant] mid-packet has no effect until that packet's tlast.
- s_axis_tvalid[grant] dropping mid-packet is legal: stay in BUSY and wait; the grant is never revoked.
- Single requester: the same port is re-granted after each packet, with the one-cycle gap.
- All req bits set: strict rotation 0,1,2,3,0...; no starvation, worst-case wait NUM_PORTS-1 packets.
- busy = (state==BUSY).

Decomposition:
- Package axis_pkg:
  - state enum {IDLE, BUSY}
  - function rr_pick(req, last) returning the index
- Sub-module rr_arbiter (combinational, parameter NUM_PORTS): inputs req, last_grant; outputs gnt_valid, gnt_id. The top holds the FSM, the grant and last_grant registers, the data mux and the output register.

Test Plan:
- Reset then idle: no tvalid for 10 cycles -> m_axis_tvalid=0, s_axis_tready=0000, busy=0 throughout.
- Single packet: port 2 sends a 3-beat packet 0xA,0xB,0xC (tlast on 0xC), m_axis_tready=1 -> output 0xA,0xB,0xC on 3 consecutive cycles, tid=2, tlast only on 0xC, first beat 2 cycles after tvalid.
- Round-robin: all 4 ports hold 2-beat packets continuously -> packet order by tid is 0,1,2,3,0,1; each pair of packets separated by exactly one input idle cycle.
- Backpressure: m_axis_tready toggles 1,0,0,1,... during a 4-beat packet from port 1 -> no beat lost or duplicated; m_axis_tdata stable while stalled; s_axis_tready[1] mirrors accept.
- Enable and mid-packet behaviour:
  - port_enable[1]=0 while port 1 is valid -> port 1 is never granted.
  - Deassert port_enable[0] mid-packet -> the packet completes intact.
  - Assert reset mid-packet -> m_axis_tvalid=0 next cycle; port 0 is granted first afterwards.
- Gappy source: port 3 drops tvalid for 5 cycles mid-packet while port 0 is requesting -> grant stays at 3, port 0 waits until port 3's tlast.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared types and the round-robin pick function for the packet arbiter.
package axis_pkg;

   typedef enum logic [0:0] {IDLE, BUSY} state_t;

   localparam int unsigned MAX_PORTS = 16;

   // First set bit of req, searching upward from last+1 with wrap at num_ports.
   function automatic logic [3:0] rr_pick(input logic [MAX_PORTS-1:0] req,
                                          input logic [3:0]           last,
                                          input int unsigned          num_ports);
      logic [3:0]  pick;
      logic        found;
      int unsigned idx;
      pick  = '0;
      found = 1'b0;
      for (int unsigned i = 1; i <= MAX_PORTS; i++) begin
         if (i <= num_ports) begin
            idx = (32'(last) + i) % num_ports;
            if (!found && req[idx[3:0]]) begin
               found = 1'b1;
               pick  = idx[3:0];
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the next requester after last_grant.
module rr_arbiter
   import axis_pkg::*;
#(
   parameter int unsigned  NUM_PORTS = 4,
   localparam int unsigned ID_WIDTH  = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [ID_WIDTH-1:0]  last_grant,
   output logic                 gnt_valid,
   output logic [ID_WIDTH-1:0]  gnt_id
);

   always_comb begin
      gnt_valid = |req;
      gnt_id    = ID_WIDTH'(rr_pick(MAX_PORTS'(req), 4'(last_grant), NUM_PORTS));
   end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin merge of NUM_PORTS AXI-stream sources onto one
// registered output; the grant is held from first beat through tlast.
module axis_packet_arbiter
   import axis_pkg::*;
#(
   parameter int unsigned  NUM_PORTS   = 4,
   parameter int unsigned  TDATA_WIDTH = 32,
   localparam int unsigned ID_WIDTH    = $clog2(NUM_PORTS)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_PORTS*TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic [NUM_PORTS-1:0]             s_axis_tlast,
   input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
   output logic [NUM_PORTS-1:0]             s_axis_tready,
   input  logic [NUM_PORTS-1:0]             port_enable,
   output logic [TDATA_WIDTH-1:0]           m_axis_tdata,
   output logic                             m_axis_tlast,
   output logic [ID_WIDTH-1:0]              m_axis_tid,
   output logic                             m_axis_tvalid,
   input  logic                             m_axis_tready,
   output logic                             busy
);

   state_t                 state_q, state_d;
   logic [ID_WIDTH-1:0]    grant_q, grant_d;
   logic [ID_WIDTH-1:0]    last_grant_q, last_grant_d;
   logic [NUM_PORTS-1:0]   req;
   logic                   gnt_valid;
   logic [ID_WIDTH-1:0]    gnt_id;
   logic                   accept;
   logic                   load;
   logic [TDATA_WIDTH-1:0] grant_data;

   logic [TDATA_WIDTH-1:0] m_data_q;
   logic                   m_last_q;
   logic [ID_WIDTH-1:0]    m_tid_q;
   logic                   m_valid_q;

   // Enable only gates new grants; an open packet keeps its grant regardless.
   assign req        = s_axis_tvalid & port_enable;
   assign grant_data = s_axis_tdata[32'(grant_q) * TDATA_WIDTH +: TDATA_WIDTH];

   rr_arbiter #(
      .NUM_PORTS(NUM_PORTS)
   ) u_rr_arbiter (
      .req       (req),
      .last_grant(last_grant_q),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id)
   );

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      last_grant_d  = last_grant_q;
      s_axis_tready = '0;
      accept        = ~m_valid_q | m_axis_tready;
      load          = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (gnt_valid) begin
               grant_d = gnt_id;
               state_d = BUSY;
            end
         end
         BUSY: begin
            s_axis_tready[grant_q] = accept;
            if (s_axis_tvalid[grant_q] && accept) begin
               load = 1'b1;
               if (s_axis_tlast[grant_q]) begin
                  last_grant_d = grant_q;
                  state_d      = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= ID_WIDTH'(NUM_PORTS - 1);
         m_data_q     <= '0;
         m_last_q     <= 1'b0;
         m_tid_q      <= '0;
         m_valid_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         if (load) begin
            m_data_q  <= grant_data;
            m_last_q  <= s_axis_tlast[grant_q];
            m_tid_q   <= grant_q;
            m_valid_q <= 1'b1;
         end else if (m_valid_q && m_axis_tready) begin
            m_valid_q <= 1'b0;
         end
      end
   end

   assign m_axis_tdata  = m_data_q;
   assign m_axis_tlast  = m_last_q;
   assign m_axis_tid    = m_tid_q;
   assign m_axis_tvalid = m_valid_q;
   assign busy          = (state_q == BUSY);

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter: queued per-port sources, an output beat log,
// and one task per scenario.
module tb_axis_packet_arbiter;

   logic         clk = 1'b0;
   logic         reset;
   logic [127:0] s_tdata;
   logic [3:0]   s_tlast, s_tvalid, s_tready, port_enable;
   logic [31:0]  m_tdata;
   logic         m_tlast, m_tvalid, m_tready, busy;
   logic [1:0]   m_tid;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [32:0] src_mem [4][64];
   int          rd [4];
   int          wr [4];
   logic [3:0]  hold = 4'b0;
   logic [3:0]  fire_snap = 4'b0;

   logic [31:0] obs_data [128];
   logic [1:0]  obs_tid [128];
   logic        obs_last [128];
   int          obs_cyc [128];
   int          obs_n = 0;
   int          stall_viol = 0;
   int          onehot_viol = 0;
   logic        stall_prev = 1'b0;
   logic [34:0] stall_word = '0;

   always #5 clk = ~clk;

   axis_packet_arbiter #(
      .NUM_PORTS  (4),
      .TDATA_WIDTH(32)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .s_axis_tdata (s_tdata),
      .s_axis_tlast (s_tlast),
      .s_axis_tvalid(s_tvalid),
      .s_axis_tready(s_tready),
      .port_enable  (port_enable),
      .m_axis_tdata (m_tdata),
      .m_axis_tlast (m_tlast),
      .m_axis_tid   (m_tid),
      .m_axis_tvalid(m_tvalid),
      .m_axis_tready(m_tready),
      .busy         (busy)
   );

   for (genvar g = 0; g < 4; g++) begin : g_src
      assign s_tvalid[g]           = (rd[g] < wr[g]) && !hold[g];
      assign s_tdata[g*32 +: 32]   = src_mem[g][rd[g] % 64][31:0];
      assign s_tlast[g]            = src_mem[g][rd[g] % 64][32];
   end

   // Inputs only change just after posedge, so negedge values equal edge values.
   always @(negedge clk) begin
      fire_snap <= s_tvalid & s_tready & {4{~reset}};
      if (m_tvalid && m_tready && !reset) begin
         obs_data[obs_n % 128] <= m_tdata;
         obs_tid[obs_n % 128]  <= m_tid;
         obs_last[obs_n % 128] <= m_tlast;
         obs_cyc[obs_n % 128]  <= cyc;
         obs_n                 <= obs_n + 1;
      end
      if (stall_prev && (!m_tvalid || {m_tlast, m_tid, m_tdata} != stall_word))
         stall_viol <= stall_viol + 1;
      stall_prev <= m_tvalid && !m_tready && !reset;
      stall_word <= {m_tlast, m_tid, m_tdata};
      if ($countones(s_tready) > 1) onehot_viol <= onehot_viol + 1;
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < 4; i++) if (fire_snap[i]) rd[i] <= rd[i] + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int p, input logic [31:0] d, input logic l);
      src_mem[p][wr[p] % 64] = {l, d};
      wr[p] = wr[p] + 1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         checks += 3;
         if (m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_tvalid cyc%0d: got %b expected 0", k, m_tvalid);
         end
         if (s_tready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_tready cyc%0d: got %b expected 0000", k, s_tready);
         end
         if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy cyc%0d: got %b expected 0", k, busy);
         end
      end
   endtask

   task automatic test_single();
      int          base, t0;
      logic [31:0] ed [3];
      ed = '{32'hA, 32'hB, 32'hC};
      base = obs_n;
      t0   = cyc;
      push(2, 32'hA, 1'b0);
      push(2, 32'hB, 1'b0);
      push(2, 32'hC, 1'b1);
      for (int k = 0; k < 40 && obs_n < base + 3; k++) tick();
      checks++;
      if (obs_n < base + 3) begin
         errors++;
         $display("FAIL single_timeout: got %0d beats expected 3", obs_n - base);
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks += 4;
            if (obs_data[base+i] !== ed[i]) begin
               errors++;
               $display("FAIL single_data[%0d]: got %h expected %h", i, obs_data[base+i], ed[i]);
            end
            if (obs_tid[base+i] !== 2'd2) begin
               errors++;
               $display("FAIL single_tid[%0d]: got %0d expected 2", i, obs_tid[base+i]);
            end
            if (obs_last[base+i] !== (i == 2)) begin
               errors++;
               $display("FAIL single_last[%0d]: got %b expected %b", i, obs_last[base+i], i == 2);
            end
            if (obs_cyc[base+i] != t0 + 2 + i) begin
               errors++;
               $display("FAIL single_cycle[%0d]: got %0d expected %0d", i, obs_cyc[base+i],
                        t0 + 2 + i);
            end
         end
      end
   endtask

   task automatic test_round_robin();
      int          base, t0, p, kk;
      logic [31:0] exp_d;
      int          order [6];
      order = '{0, 1, 2, 3, 0, 1};
      reset = 1'b1;
      tick();
      reset = 1'b0;
      base = obs_n;
      t0   = cyc;
      for (int q = 0; q < 4; q++)
         for (int k = 0; k < ((q < 2) ? 2 : 1); k++) begin
            push(q, 32'h100 * q + 32'h10 * k, 1'b0);
            push(q, 32'h100 * q + 32'h10 * k + 1, 1'b1);
         end
      for (int k = 0; k < 80 && obs_n < base + 12; k++) tick();
      checks++;
      if (obs_n < base + 12) begin
         errors++;
         $display("FAIL rr_timeout: got %0d beats expected 12", obs_n - base);
      end else begin
         for (int j = 0; j < 6; j++) begin
            p  = order[j];
            kk = j / 4;
            for (int b = 0; b < 2; b++) begin
               exp_d = 32'h100 * p + 32'h10 * kk + b;
               checks += 4;
               if (obs_tid[base+2*j+b] !== 2'(p)) begin
                  errors++;
                  $display("FAIL rr_tid pkt%0d: got %0d expected %0d", j, obs_tid[base+2*j+b], p);
               end
               if (obs_data[base+2*j+b] !== exp_d) begin
                  errors++;
                  $display("FAIL rr_data pkt%0d b%0d: got %h expected %h", j, b,
                           obs_data[base+2*j+b], exp_d);
               end
               if (obs_last[base+2*j+b] !== (b == 1)) begin
                  errors++;
                  $display("FAIL rr_last pkt%0d b%0d: got %b expected %b", j, b,
                           obs_last[base+2*j+b], b == 1);
               end
               if (obs_cyc[base+2*j+b] != t0 + 2 + 3 * j + b) begin
                  errors++;
                  $display("FAIL rr_cycle pkt%0d b%0d: got %0d expected %0d", j, b,
                           obs_cyc[base+2*j+b], t0 + 2 + 3 * j + b);
               end
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int base;
      base = obs_n;
      for (int i = 0; i < 4; i++) push(1, 32'h1000 + i, i == 3);
      for (int k = 0; k < 60 && obs_n < base + 4; k++) begin
         m_tready = (k % 3 == 0);
         #1;
         if (busy) begin
            checks++;
            if (s_tready !== (4'b0010 & {4{~m_tvalid | m_tready}})) begin
               errors++;
               $display("FAIL bp_tready k%0d: got %b expected %b", k, s_tready,
                        4'b0010 & {4{~m_tvalid | m_tready}});
            end
         end
         tick();
      end
      m_tready = 1'b1;
      repeat (5) tick();
      checks += 2;
      if (obs_n != base + 4) begin
         errors++;
         $display("FAIL bp_count: got %0d beats expected 4", obs_n - base);
      end
      if (stall_viol != 0) begin
         errors++;
         $display("FAIL bp_stable: got %0d unstable stalls expected 0", stall_viol);
      end
      for (int i = 0; i < 4; i++) begin
         checks += 3;
         if (obs_data[base+i] !== 32'h1000 + i) begin
            errors++;
            $display("FAIL bp_data[%0d]: got %h expected %h", i, obs_data[base+i], 32'h1000 + i);
         end
         if (obs_tid[base+i] !== 2'd1) begin
            errors++;
            $display("FAIL bp_tid[%0d]: got %0d expected 1", i, obs_tid[base+i]);
         end
         if (obs_last[base+i] !== (i == 3)) begin
            errors++;
            $display("FAIL bp_last[%0d]: got %b expected %b", i, obs_last[base+i], i == 3);
         end
      end
   endtask

   task automatic test_enable();
      int base;
      port_enable = 4'b1101;
      base = obs_n;
      push(1, 32'h2100, 1'b0);
      push(1, 32'h2101, 1'b1);
      push(2, 32'h2200, 1'b0);
      push(2, 32'h2201, 1'b1);
      repeat (30) tick();
      checks += 5;
      if (obs_n != base + 2) begin
         errors++;
         $display("FAIL en_count: got %0d beats expected 2", obs_n - base);
      end
      if (obs_tid[base] !== 2'd2 || obs_tid[base+1] !== 2'd2) begin
         errors++;
         $display("FAIL en_tid: got %0d,%0d expected 2,2", obs_tid[base], obs_tid[base+1]);
      end
      if (obs_data[base+1] !== 32'h2201) begin
         errors++;
         $display("FAIL en_data: got %h expected 00002201", obs_data[base+1]);
      end
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL en_busy: got %b expected 0", busy);
      end
      if (s_tready !== 4'b0000) begin
         errors++;
         $display("FAIL en_tready: got %b expected 0000", s_tready);
      end
      wr[1] = rd[1];
      port_enable = 4'b1111;
      tick();
      // Drop the enable of the granted port after its first beat.
      base = obs_n;
      for (int i = 0; i < 4; i++) push(0, 32'h3000 + i, i == 3);
      for (int k = 0; k < 20 && obs_n <= base; k++) tick();
      port_enable[0] = 1'b0;
      for (int k = 0; k < 40 && obs_n < base + 4; k++) tick();
      checks++;
      if (obs_n < base + 4) begin
         errors++;
         $display("FAIL midpkt_timeout: got %0d beats expected 4", obs_n - base);
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks += 2;
            if (obs_data[base+i] !== 32'h3000 + i || obs_tid[base+i] !== 2'd0) begin
               errors++;
               $display("FAIL midpkt_beat[%0d]: got %h/tid%0d expected %h/tid0", i,
                        obs_data[base+i], obs_tid[base+i], 32'h3000 + i);
            end
            if (obs_last[base+i] !== (i == 3)) begin
               errors++;
               $display("FAIL midpkt_last[%0d]: got %b expected %b", i, obs_last[base+i], i == 3);
            end
         end
      end
      port_enable = 4'b1111;
      tick();
   endtask

   task automatic test_reset_mid();
      int base;
      base = obs_n;
      for (int i = 0; i < 4; i++) push(2, 32'h4000 + i, i == 3);
      for (int k = 0; k < 30 && obs_n < base + 2; k++) tick();
      reset = 1'b1;
      wr[2] = rd[2];
      tick();
      checks += 3;
      if (m_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_tvalid: got %b expected 0", m_tvalid);
      end
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_busy: got %b expected 0", busy);
      end
      if (s_tready !== 4'b0000) begin
         errors++;
         $display("FAIL rstmid_tready: got %b expected 0000", s_tready);
      end
      reset = 1'b0;
      base = obs_n;
      push(2, 32'h4200, 1'b0);
      push(2, 32'h4201, 1'b1);
      push(0, 32'h4050, 1'b1);
      for (int k = 0; k < 40 && obs_n < base + 3; k++) tick();
      checks++;
      if (obs_n < base + 3) begin
         errors++;
         $display("FAIL rstmid_timeout: got %0d beats expected 3", obs_n - base);
      end else begin
         checks += 3;
         if (obs_tid[base] !== 2'd0 || obs_data[base] !== 32'h4050 || obs_last[base] !== 1'b1)
         begin
            errors++;
            $display("FAIL rstmid_first: got %h/tid%0d expected 00004050/tid0",
                     obs_data[base], obs_tid[base]);
         end
         if (obs_tid[base+1] !== 2'd2 || obs_data[base+1] !== 32'h4200) begin
            errors++;
            $display("FAIL rstmid_second: got %h/tid%0d expected 00004200/tid2",
                     obs_data[base+1], obs_tid[base+1]);
         end
         if (obs_data[base+2] !== 32'h4201 || obs_last[base+2] !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_third: got %h/last%b expected 00004201/last1",
                     obs_data[base+2], obs_last[base+2]);
         end
      end
   endtask

   task automatic test_gappy();
      int          base;
      logic [31:0] ed [6];
      logic [1:0]  et [6];
      ed = '{32'h6000, 32'h6001, 32'h6002, 32'h6003, 32'h6100, 32'h6101};
      et = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0};
      base = obs_n;
      for (int i = 0; i < 4; i++) push(3, 32'h6000 + i, i == 3);
      for (int k = 0; k < 20 && obs_n <= base; k++) tick();
      hold[3] = 1'b1;
      push(0, 32'h6100, 1'b0);
      push(0, 32'h6101, 1'b1);
      for (int k = 0; k < 5; k++) begin
         tick();
         checks += 2;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL gap_busy cyc%0d: got %b expected 1", k, busy);
         end
         if (s_tready !== 4'b1000) begin
            errors++;
            $display("FAIL gap_tready cyc%0d: got %b expected 1000", k, s_tready);
         end
      end
      hold[3] = 1'b0;
      for (int k = 0; k < 40 && obs_n < base + 6; k++) tick();
      checks++;
      if (obs_n < base + 6) begin
         errors++;
         $display("FAIL gap_timeout: got %0d beats expected 6", obs_n - base);
      end else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs_data[base+i] !== ed[i] || obs_tid[base+i] !== et[i]) begin
               errors++;
               $display("FAIL gap_beat[%0d]: got %h/tid%0d expected %h/tid%0d", i,
                        obs_data[base+i], obs_tid[base+i], ed[i], et[i]);
            end
         end
      end
   endtask

   initial begin
      reset       = 1'b1;
      m_tready    = 1'b1;
      port_enable = 4'b1111;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_enable();
      test_reset_mid();
      test_gappy();
      checks++;
      if (onehot_viol != 0) begin
         errors++;
         $display("FAIL tready_onehot: got %0d violations expected 0", onehot_viol);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
